alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Upstream issue stage for `ALU_DESIGN`. It accepts ALU operations from a stimulus or sequencer source over a valid/ready handshake and buffers them in a small circular FIFO. It drives them onto the ALU input pins (OPA, OPB, CMD, MODE, CIN, INP_VALID, CE) at one operation per cycle, inserting idle gap cycles after multiply commands. Each issued operation carries a wrapping tag so the downstream checker can pair ALU results with requests.

## Interface
- WIDTH, 8, operand width (matches ALU OPA/OPB)
- CMD_WIDTH, 4, command width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- MUL_GAP, 2, idle cycles inserted after a multiply issue (≥0)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset (low = reset asserted)
- IN_VALID  in  1  request valid
- IN_READY  out  1  request accepted when IN_VALID && IN_READY at rising edge
- IN_OPA, IN_OPB  in  WIDTH  operands
- IN_CMD  in  CMD_WIDTH  command
- IN_MODE  in  1  1 = arithmetic, 0 = logical
- IN_CIN  in  1  carry in
- IN_INP_VALID  in  2  operand-valid code, passed through unchanged
- HOLD  in  1  freeze issue; ALU clock-enable deasserted
- FLUSH  in  1  synchronous discard of all queued and gap state
- OPA, OPB  out  WIDTH  to ALU
- CMD  out  CMD_WIDTH  to ALU
- MODE, CIN  out  1  to ALU
- INP_VALID  out  2  to ALU; 2'b00 on non-issue cycles
- CE  out  1  to ALU clock enable
- ISSUE  out  1  pulse: ALU pins carry a new operation this cycle
- ISSUE_TAG  out  4  tag of operation on pins; wraps 15→0
- COUNT  out  $clog2(DEPTH+1)  occupied entries

## Operation
- FIFO: write pointer, read pointer and count registers. Pointers wrap modulo DEPTH. No write-to-issue bypass.
- IN_READY = RST && !FLUSH && (COUNT < DEPTH). A full FIFO deasserts IN_READY even if a pop happens the same cycle.
- Issue FSM states:
  - IDLE: FIFO empty or HOLD.
  - RUN: a pop is eligible.
  - GAP: the gap counter is non-zero.
- Pop condition: COUNT>0 && !HOLD && !FLUSH && gap_cnt==0. On pop, the head entry is registered onto the output pins, ISSUE=1, INP_VALID = entry code, and ISSUE_TAG increments, so the first issued op carries tag 0.
- Multiply: an issued entry with MODE=1 and CMD∈{9,10} loads gap_cnt=MUL_GAP and the FSM goes to GAP. gap_cnt decrements only in non-HOLD cycles, and there are no pops while it is non-zero. Returns to RUN/IDLE when gap_cnt reaches 0.
- Non-issue cycles:
  - ISSUE=0 and INP_VALID=2'b00.
  - OPA/OPB/CMD/MODE/CIN hold their last values.
- CE=0 in every cycle in which HOLD is sampled high, otherwise CE=1.
- HOLD does not block FIFO writes.
- FLUSH: at that edge, count, pointers and gap_cnt are cleared and the FSM goes to IDLE. The following cycle has ISSUE=0 and INP_VALID=0. A write presented the same cycle is dropped (IN_READY=0). ISSUE_TAG is not cleared.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Entries with IN_INP_VALID=2'b00 are queued and issued normally. No filtering.

## Timing
- Reset (RST low, asynchronous) forces:
  - count, pointers, gap_cnt = 0, FSM = IDLE
  - OPA, OPB, CMD, MODE, CIN, INP_VALID, ISSUE = 0
  - CE = 0, ISSUE_TAG = 15, so the first issue shows 0
  - IN_READY = 0
- Reset mid-operation discards all entries and gap state immediately.
- Outputs are valid from the first edge after RST rises: CE=1, IN_READY=1.
- Latency: a request accepted at edge k into an empty, un-held, gap-free queue appears on the ALU pins after edge k+1 with ISSUE=1.
- Throughput: one issue per cycle for non-multiply ops.
- A multiply issued at edge k blocks issue at edges k+1…k+MUL_GAP. The next pop is at edge k+MUL_GAP+1.
- All outputs are registered except IN_READY, which is combinational from count, FLUSH and RST.

## Test plan
- Reset release, then push OPA=8'h12, OPB=8'h34, CMD=0, MODE=1, INP_VALID=3 at edge 1 -> after edge 2: OPA=12, OPB=34, ISSUE=1, ISSUE_TAG=0, CE=1. Next cycle: INP_VALID=0.
- Push 5 back-to-back ops with issue held via HOLD=1 -> 4 accepted, IN_READY=0 on the 5th with COUNT=4 and CE=0. Release HOLD -> 4 consecutive ISSUE pulses with tags 0..3 in order. Sender retries the 5th, which is accepted once COUNT<4.
- Push MUL (MODE=1, CMD=9) then ADD, MUL_GAP=2 -> MUL issues at cycle t, ADD issues at t+3, and INP_VALID=0 at t+1 and t+2.
- 3 entries queued, FLUSH=1 for one cycle with IN_VALID=1 -> COUNT=0, no ISSUE the next cycle, flushed-cycle write dropped. Next push issues with the tag continuing from the previous value.
- 17 single ops -> ISSUE_TAG sequence 0..15, 0. Pointers wrap with data intact (scoreboard compare against pushed order).
- Assert RST low while a gap is active and 2 entries are queued -> all outputs 0, COUNT=0 immediately. After release, no stale issue occurs.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Issue queue in front of ALU_DESIGN: buffers requests in a circular FIFO and
// drives the ALU pins at one op per cycle, with idle gap cycles after multiplies.
module alu_issue_queue #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int MUL_GAP   = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [WIDTH-1:0]             IN_OPA,
  input  logic [WIDTH-1:0]             IN_OPB,
  input  logic [CMD_WIDTH-1:0]         IN_CMD,
  input  logic                         IN_MODE,
  input  logic                         IN_CIN,
  input  logic [1:0]                   IN_INP_VALID,
  input  logic                         HOLD,
  input  logic                         FLUSH,
  output logic [WIDTH-1:0]             OPA,
  output logic [WIDTH-1:0]             OPB,
  output logic [CMD_WIDTH-1:0]         CMD,
  output logic                         MODE,
  output logic                         CIN,
  output logic [1:0]                   INP_VALID,
  output logic                         CE,
  output logic                         ISSUE,
  output logic [3:0]                   ISSUE_TAG,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = $clog2(MUL_GAP+2);
  localparam int EW = 2*WIDTH + CMD_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [GW-1:0]        gap_q, gap_d;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 mode_q, cin_q, ce_q, issue_q;
  logic [1:0]           iv_q;
  logic [3:0]           tag_q;

  logic                 push, pop, h_mul;
  logic [WIDTH-1:0]     h_opa, h_opb;
  logic [CMD_WIDTH-1:0] h_cmd;
  logic                 h_mode, h_cin;
  logic [1:0]           h_iv;

  assign IN_READY = RST && !FLUSH && (count_q < CW'(DEPTH));
  assign push     = IN_VALID && IN_READY;
  // GAP state is held exactly while the gap counter is non-zero
  assign pop      = (count_q != '0) && !HOLD && !FLUSH && (state_q != GAP);
  assign {h_opa, h_opb, h_cmd, h_mode, h_cin, h_iv} = mem_q[rptr_q];
  assign h_mul    = h_mode && ((h_cmd == CMD_WIDTH'(9)) || (h_cmd == CMD_WIDTH'(10)));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    gap_d   = gap_q;
    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      gap_d   = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (pop && h_mul)                gap_d = GW'(MUL_GAP);
      else if ((gap_q != '0) && !HOLD) gap_d = gap_q - 1'b1;
    end
    if (gap_d != '0)                   state_d = GAP;
    else if ((count_d != '0) && !HOLD) state_d = RUN;
    else                               state_d = IDLE;
  end

  // Payload storage carries no reset; only valid entries are ever read
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN, IN_INP_VALID};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      iv_q    <= 2'b00;
      issue_q <= 1'b0;
      ce_q    <= 1'b0;
      tag_q   <= 4'hF;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      state_q <= state_d;
      ce_q    <= !HOLD;
      issue_q <= pop;
      if (pop) begin
        opa_q  <= h_opa;
        opb_q  <= h_opb;
        cmd_q  <= h_cmd;
        mode_q <= h_mode;
        cin_q  <= h_cin;
        iv_q   <= h_iv;
        tag_q  <= tag_q + 1'b1;
      end else begin
        iv_q   <= 2'b00;
      end
    end
  end

  assign OPA       = opa_q;
  assign OPB       = opb_q;
  assign CMD       = cmd_q;
  assign MODE      = mode_q;
  assign CIN       = cin_q;
  assign INP_VALID = iv_q;
  assign CE        = ce_q;
  assign ISSUE     = issue_q;
  assign ISSUE_TAG = tag_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: accepted requests are queued as expected
// issues; a negedge monitor pairs every ISSUE pulse with the oldest request.
module tb_alu_issue_queue;
  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic [1:0] iv;
  } ent_t;

  logic       CLK, RST, IN_VALID, IN_READY;
  logic [7:0] IN_OPA, IN_OPB;
  logic [3:0] IN_CMD;
  logic       IN_MODE, IN_CIN;
  logic [1:0] IN_INP_VALID;
  logic       HOLD, FLUSH;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN;
  logic [1:0] INP_VALID;
  logic       CE, ISSUE;
  logic [3:0] ISSUE_TAG;
  logic [2:0] COUNT;

  alu_issue_queue #(.WIDTH(8), .CMD_WIDTH(4), .DEPTH(4), .MUL_GAP(2)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CMD(IN_CMD), .IN_MODE(IN_MODE),
    .IN_CIN(IN_CIN), .IN_INP_VALID(IN_INP_VALID), .HOLD(HOLD), .FLUSH(FLUSH),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
    .INP_VALID(INP_VALID), .CE(CE), .ISSUE(ISSUE), .ISSUE_TAG(ISSUE_TAG),
    .COUNT(COUNT)
  );

  ent_t       sb[$];
  int         iss_cyc[$];
  logic [3:0] exp_tag;
  ent_t       mon_e;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (ISSUE) begin
        iss_cyc.push_back(cyc);
        if (sb.size() == 0) chk("issue_unexpected", {31'd0, ISSUE}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("issue_data", {8'd0, OPA, OPB, CMD, MODE, CIN, INP_VALID}, {8'd0, mon_e});
          chk("issue_tag", {28'd0, ISSUE_TAG}, {28'd0, exp_tag});
          exp_tag = exp_tag + 4'd1;
        end
      end else begin
        chk("idle_inp_valid", {30'd0, INP_VALID}, 32'd0);
      end
    end
  end

  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic m, input logic ci, input logic [1:0] iv);
    IN_OPA = a; IN_OPB = b; IN_CMD = c; IN_MODE = m; IN_CIN = ci; IN_INP_VALID = iv;
  endtask

  // Advance one cycle from a negedge, logging the request if it will be accepted
  task automatic step();
    bit acc;
    #1;
    acc = IN_VALID && IN_READY;
    if (acc) sb.push_back({IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN, IN_INP_VALID});
    @(posedge CLK);
    @(negedge CLK);
    if (acc) IN_VALID = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic m, input logic ci, input logic [1:0] iv);
    int n;
    n = 0;
    set_op(a, b, c, m, ci, iv);
    IN_VALID = 1'b1;
    while (IN_VALID) begin
      if (n == 20) begin
        chk("push_timeout", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b0;
      end else begin
        step();
        n++;
      end
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    chk(nm, sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    IN_VALID = 1'b0; HOLD = 1'b0; FLUSH = 1'b0; RST = 1'b0;
    sb.delete();
    exp_tag = 4'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_opa", {24'd0, OPA}, 32'd0);
    chk("rst_opb", {24'd0, OPB}, 32'd0);
    chk("rst_cmd", {28'd0, CMD}, 32'd0);
    chk("rst_mode_cin", {30'd0, MODE, CIN}, 32'd0);
    chk("rst_inp_valid", {30'd0, INP_VALID}, 32'd0);
    chk("rst_issue", {31'd0, ISSUE}, 32'd0);
    chk("rst_ce", {31'd0, CE}, 32'd0);
    chk("rst_tag", {28'd0, ISSUE_TAG}, 32'hF);
    chk("rst_count", {29'd0, COUNT}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
  endtask

  initial begin
    int exp_d[4];
    exp_d = '{3, 1, 3, 1};
    RST = 1'b1; IN_VALID = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
    set_op(8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 2'b00);
    exp_tag = 4'd0;
    #1 RST = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Latency: push at edge 1, pins loaded after edge 2
    push(8'h12, 8'h34, 4'h0, 1'b1, 1'b0, 2'b11);
    chk("t1_count_after_push", {29'd0, COUNT}, 32'd1);
    chk("t1_no_issue_yet", {31'd0, ISSUE}, 32'd0);
    chk("t1_ce_after_release", {31'd0, CE}, 32'd1);
    step();
    chk("t1_issue", {31'd0, ISSUE}, 32'd1);
    chk("t1_opa_opb", {16'd0, OPA, OPB}, 32'h1234);
    chk("t1_tag", {28'd0, ISSUE_TAG}, 32'd0);
    chk("t1_inp_valid", {30'd0, INP_VALID}, 32'd3);
    step();
    chk("t1_next_issue", {31'd0, ISSUE}, 32'd0);
    chk("t1_next_inp_valid", {30'd0, INP_VALID}, 32'd0);
    chk("t1_opa_held", {24'd0, OPA}, 32'h12);

    // Fill under HOLD, then release and retry the rejected fifth request
    do_reset();
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 8'h40 + 8'(i), 4'(i + 1), 1'b0, 1'b1, 2'(i));
    set_op(8'h55, 8'h66, 4'h3, 1'b1, 1'b0, 2'b10);
    IN_VALID = 1'b1;
    #1;
    chk("t2_full_in_ready", {31'd0, IN_READY}, 32'd0);
    chk("t2_full_count", {29'd0, COUNT}, 32'd4);
    chk("t2_hold_ce", {31'd0, CE}, 32'd0);
    HOLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_issue_run", {31'd0, ISSUE}, 32'd1);
      chk("t2_tag_order", {28'd0, ISSUE_TAG}, 32'(i));
      chk("t2_ce_released", {31'd0, CE}, 32'd1);
    end
    step();
    chk("t2_fifth_issue", {31'd0, ISSUE}, 32'd1);
    chk("t2_fifth_tag", {28'd0, ISSUE_TAG}, 32'd4);
    chk("t2_count_empty", {29'd0, COUNT}, 32'd0);

    // Multiply gaps: CMD 9/10 in arithmetic mode block two edges, logical CMD 9 does not
    do_reset();
    iss_cyc.delete();
    push(8'h03, 8'h04, 4'd9,  1'b1, 1'b0, 2'b11);
    push(8'h05, 8'h06, 4'd0,  1'b1, 1'b1, 2'b11);
    push(8'h07, 8'h08, 4'd10, 1'b1, 1'b0, 2'b11);
    push(8'h09, 8'h0A, 4'd9,  1'b0, 1'b0, 2'b01);
    push(8'h0B, 8'h0C, 4'd1,  1'b1, 1'b0, 2'b11);
    drain("t3_drain");
    chk("t3_issue_count", iss_cyc.size(), 32'd5);
    if (iss_cyc.size() == 5)
      for (int i = 0; i < 4; i++) chk("t3_issue_spacing", iss_cyc[i+1] - iss_cyc[i], exp_d[i]);

    // FLUSH drops queued entries and the concurrent write; tag keeps counting
    do_reset();
    push(8'hA1, 8'hB1, 4'h2, 1'b0, 1'b0, 2'b11);
    step();
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 8'hD0, 4'h1, 1'b1, 1'b0, 2'b11);
    chk("t4_queued", {29'd0, COUNT}, 32'd3);
    FLUSH = 1'b1;
    set_op(8'hEE, 8'hEE, 4'h1, 1'b1, 1'b0, 2'b11);
    IN_VALID = 1'b1;
    #1;
    chk("t4_flush_in_ready", {31'd0, IN_READY}, 32'd0);
    sb.delete();
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0; HOLD = 1'b0;
    chk("t4_flush_count", {29'd0, COUNT}, 32'd0);
    chk("t4_flush_issue", {31'd0, ISSUE}, 32'd0);
    step();
    chk("t4_after_flush_issue", {31'd0, ISSUE}, 32'd0);
    chk("t4_dropped_write", {29'd0, COUNT}, 32'd0);
    push(8'h77, 8'h88, 4'h4, 1'b0, 1'b1, 2'b10);
    step();
    chk("t4_post_issue", {31'd0, ISSUE}, 32'd1);
    chk("t4_post_tag", {28'd0, ISSUE_TAG}, 32'd1);
    chk("t4_post_opa", {24'd0, OPA}, 32'h77);

    // Seventeen ops: tags wrap 15 -> 0, pointers wrap with data intact
    do_reset();
    for (int i = 0; i < 17; i++)
      push(8'(i * 3 + 1), ~8'(i), 4'(i % 8), i[0], i[1], 2'(i));
    drain("t5_drain");
    chk("t5_final_tag", {28'd0, ISSUE_TAG}, 32'd0);

    // Asynchronous reset with a gap active and two entries queued
    do_reset();
    push(8'h11, 8'h22, 4'd9, 1'b1, 1'b0, 2'b11);
    push(8'h33, 8'h44, 4'd0, 1'b1, 1'b0, 2'b11);
    push(8'h55, 8'h66, 4'd0, 1'b1, 1'b0, 2'b11);
    chk("t6_count_before", {29'd0, COUNT}, 32'd2);
    RST = 1'b0;
    #1;
    chk_reset_outputs();
    sb.delete();
    exp_tag = 4'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_stale_issue", {31'd0, ISSUE}, 32'd0);
    end
    chk("t6_count", {29'd0, COUNT}, 32'd0);
    chk("t6_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("t6_ce", {31'd0, CE}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
